f32_bcd_seq: RTL
================

Name: f32_bcd_seq

Overview:
- Multi-cycle, handshaked converter from an IEEE-754 float32 to signed fixed-point decimal: INT_DIGITS integer BCD digits and FRAC_DIGITS fractional BCD digits, plus classification flags.
- Feeds the 7-segment/display path: one operand in, one decimal result out, with back-pressure on both sides.
- Supersedes the combinational converter. Adds true decimal (double-dabble) conversion of the integer part, multiply-by-10 fraction digits, parametrised digit counts, and inf/NaN/zero/overflow detection.

Parameters:
- INT_DIGITS, 8: integer BCD digits.
- INT_BITS, 27: binary integer-part width; must satisfy 2^INT_BITS >= 10^INT_DIGITS.
- FRAC_DIGITS, 8: fractional BCD digits produced.
- FRAC_BITS, 32: binary fraction-register width; bits shifted below it are truncated.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: operand valid.
- in_ready, out, 1: converter can accept an operand.
- bin, in, 32: ieee754 float32 operand.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- sign, out, 1: bin[31] of the converted operand.
- int_bcd, out, 4*INT_DIGITS: integer digits; digit k is [4k+3:4k], k=0 is the units digit.
- frac_bcd, out, 4*FRAC_DIGITS: fraction digits; digit FRAC_DIGITS-1 is the tenths digit, digit 0 is the least significant.
- is_zero, out, 1: operand is zero or denormal.
- is_inf, out, 1: exponent 255 and mantissa 0.
- is_nan, out, 1: exponent 255 and mantissa nonzero.
- overflow, out, 1: integer part does not fit in INT_DIGITS.

Behaviour:
- Reset (rst_n low, async): state IDLE. in_ready=1. out_valid=0. All data outputs and flags = 0. Any in-flight conversion is discarded. No output after reset release until a new accept.
- States: IDLE -> ALIGN -> INT -> FRAC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready at a clock edge; the operand is registered. in_ready drops the next cycle.
  - in_ready is 0 in every other state.
- ALIGN (1 cycle):
  - e = exp-127.
  - m = {1,frac23} for exp 1..254; m = 0 for exp 0 (denormals flush to zero).
  - Form |x| = m*2^(e-23) as an INT_BITS-bit integer I and a FRAC_BITS-bit fraction F.
  - Right shifts truncate.
  - overflow is set if e >= INT_BITS.
  - Flags are classified here. For inf/NaN/zero, I and F are forced to 0.
- INT (exactly INT_BITS cycles): one double-dabble step per cycle on I.
  - Add 3 to every BCD nibble > 4, then shift left 1.
  - A 1 shifted out of the top digit, or a top-digit carry, sets overflow.
- FRAC (exactly FRAC_DIGITS cycles): per cycle, F <- 10*F, computed as (F<<3)+(F<<1).
  - The carry-out nibble (value 0..9) is the next digit, shifted into frac_bcd from the tenths position downward.
  - The fraction is truncated, not rounded.
- DONE:
  - out_valid=1; all outputs are stable.
  - Hold while out_ready=0.
  - On out_valid & out_ready: go to IDLE; out_valid=0 next cycle. Outputs retain their last values until the next ALIGN.
- Latency: fixed for all operands, including specials. out_valid rises exactly 2+INT_BITS+FRAC_DIGITS edges after the accepting edge (37 at defaults).
- Throughput: one operand per latency plus the handshake cycles. There is no overlap.
- Outputs during processing: int_bcd and frac_bcd may change while out_valid=0; consumers sample them only when out_valid=1.
- When overflow=1: int_bcd = all 9s (saturate) and frac_bcd = 0.
- Flag exclusivity: at most one of is_zero/is_inf/is_nan is set. overflow is 0 whenever any of them is set.
- Negative zero: sign=1, is_zero=1.

Test Plan:
- 0x3F800000 (1.0), out_ready=1 -> out_valid exactly 37 cycles after accept; int_bcd=00000001; frac_bcd=00000000; all flags 0; in_ready low throughout.
- 0xC1460000 (-12.375) -> sign=1; int_bcd=00000012; frac_bcd=37500000.
- 0x3DCCCCCD (0.1) -> int_bcd=00000000; frac_bcd=10000000 (truncated).
- 0x7F800000 -> is_inf=1. 0x7FC00000 -> is_nan=1. 0x80000001 -> is_zero=1, sign=1. Digits 0 in all three cases.
- 0x4CBEBC20 (100000000.0) -> overflow=1, int_bcd=99999999. 0x4B800000 (16777216.0) -> int_bcd=16777216, overflow=0.
- out_ready held 0 for 10 cycles in DONE -> out_valid and data stable, in_ready=0. Release -> one transfer, then in_ready=1.
- rst_n pulsed low mid-INT -> outputs clear immediately, in_ready=1. A new operand then converts correctly with full latency.

Source files
------------

// File: rtl/f32_bcd_seq.sv
// rtl/f32_bcd_seq.sv - multi-cycle float32 to signed fixed-point BCD converter
// Integer part via double-dabble, fraction via repeated multiply-by-10.
module f32_bcd_seq #(
  parameter int INT_DIGITS  = 8,
  parameter int INT_BITS    = 27,
  parameter int FRAC_DIGITS = 8,
  parameter int FRAC_BITS   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              bin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sign,
  output logic [4*INT_DIGITS-1:0]  int_bcd,
  output logic [4*FRAC_DIGITS-1:0] frac_bcd,
  output logic                     is_zero,
  output logic                     is_inf,
  output logic                     is_nan,
  output logic                     overflow
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int IW = 4 * INT_DIGITS;
  localparam int FW = 4 * FRAC_DIGITS;
  localparam int CW = $clog2(INT_BITS + FRAC_DIGITS + 1);
  localparam logic [IW-1:0] NINES = {INT_DIGITS{4'h9}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_INT, S_FRAC, S_DONE} state_t;

  state_t               state;
  logic [31:0]          op;
  logic [INT_BITS-1:0]  ireg;
  logic [FRAC_BITS-1:0] freg;
  logic [CW-1:0]        cnt;

  logic [7:0]         op_exp;
  logic [22:0]        op_man;
  logic signed [10:0] e_s;
  logic signed [10:0] sh;
  logic [10:0]        sh_neg;
  logic [W-1:0]       m_w;
  logic [W-1:0]       fixed_w;
  logic               a_zero, a_inf, a_nan, a_ovf;

  assign op_exp = op[30:23];
  assign op_man = op[22:0];

  // Place m*2^(e-23) in a fixed-point word with FRAC_BITS fractional bits.
  always_comb begin
    e_s    = $signed({3'b000, op_exp}) - 11'sd127;
    sh     = e_s + $signed(11'(FRAC_BITS - 23));
    sh_neg = 11'(-sh);
    m_w    = (op_exp == 8'd0) ? '0 : W'({1'b1, op_man});
    if (sh >= 11'sd0) fixed_w = m_w << sh[9:0];
    else              fixed_w = m_w >> sh_neg;
    a_zero = (op_exp == 8'd0);
    a_inf  = (op_exp == 8'hff) && (op_man == 23'd0);
    a_nan  = (op_exp == 8'hff) && (op_man != 23'd0);
    a_ovf  = !(a_zero || a_inf || a_nan) && (e_s >= $signed(11'(INT_BITS)));
  end

  logic [IW-1:0] bcd_adj;
  always_comb begin
    bcd_adj = int_bcd;
    for (int k = 0; k < INT_DIGITS; k++) begin
      if (int_bcd[4*k +: 4] > 4'd4) bcd_adj[4*k +: 4] = int_bcd[4*k +: 4] + 4'd3;
    end
  end

  logic [FRAC_BITS+3:0] f_wide, f_x10;
  always_comb begin
    f_wide = {4'b0000, freg};
    f_x10  = (f_wide << 3) + (f_wide << 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      op        <= '0;
      ireg      <= '0;
      freg      <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      int_bcd   <= '0;
      frac_bcd  <= '0;
      is_zero   <= 1'b0;
      is_inf    <= 1'b0;
      is_nan    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op       <= bin;
            in_ready <= 1'b0;
            state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          sign     <= op[31];
          is_zero  <= a_zero;
          is_inf   <= a_inf;
          is_nan   <= a_nan;
          overflow <= a_ovf;
          int_bcd  <= '0;
          frac_bcd <= '0;
          if (a_zero || a_inf || a_nan || a_ovf) begin
            ireg <= '0;
            freg <= '0;
          end else begin
            ireg <= fixed_w[W-1:FRAC_BITS];
            freg <= fixed_w[FRAC_BITS-1:0];
          end
          cnt   <= '0;
          state <= S_INT;
        end
        S_INT: begin
          int_bcd <= {bcd_adj[IW-2:0], ireg[INT_BITS-1]};
          ireg    <= ireg << 1;
          if (bcd_adj[IW-1]) overflow <= 1'b1;
          if (cnt == CW'(INT_BITS - 1)) begin
            cnt   <= '0;
            state <= S_FRAC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FRAC: begin
          freg     <= f_x10[FRAC_BITS-1:0];
          frac_bcd <= {frac_bcd[FW-5:0], f_x10[FRAC_BITS+3:FRAC_BITS]};
          if (cnt == CW'(FRAC_DIGITS - 1)) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          // First DONE cycle applies saturation and raises out_valid.
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (overflow) begin
              int_bcd  <= NINES;
              frac_bcd <= '0;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
